// File: rtl/ram_fifo_arb_pkg.sv
// ram_fifo_arb_pkg: producer identifiers shared by the FIFO controller and its arbiter
package ram_fifo_arb_pkg;
   typedef enum logic {SRC_W0 = 1'b0, SRC_W1 = 1'b1} src_e;
endpackage

// File: rtl/ram_fifo_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favours the producer not granted last
module rr_arb2
   import ram_fifo_arb_pkg::*;
(
   input  logic       clk1,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] rdy,
   output logic [1:0] gnt
);
   src_e last_gnt;
   // rdy ignores a producer's own request so it can be presented as a ready
   always_comb begin
      rdy[0] = en & (!req[1] | (last_gnt == SRC_W1));
      rdy[1] = en & (!req[0] | (last_gnt == SRC_W0));
      gnt    = rdy & req;
   end
   always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) last_gnt <= SRC_W1;
      else if (|gnt) last_gnt <= gnt[1] ? SRC_W1 : SRC_W0;
endmodule

// File: rtl/ram_fifo_arb.sv
// ram_fifo_arb: two-writer one-reader FIFO controller sequencing an external dual-port RAM
module ram_fifo_arb
   import ram_fifo_arb_pkg::*;
#(
   parameter int DataDepth    = 32,
   parameter int AddrBitWidth = 8
) (
   input  logic                    clk1,
   input  logic                    rst_n,
   input  logic                    w0_valid,
   input  logic [DataDepth-1:0]    w0_data,
   output logic                    w0_ready,
   input  logic                    w1_valid,
   input  logic [DataDepth-1:0]    w1_data,
   output logic                    w1_ready,
   output logic                    r_valid,
   output logic [DataDepth-1:0]    r_data,
   input  logic                    r_ready,
   output logic [AddrBitWidth:0]   count,
   output logic                    full,
   output logic                    empty,
   output logic                    ram_we,
   output logic [AddrBitWidth-1:0] ram_addr_in,
   output logic [DataDepth-1:0]    ram_d,
   output logic [AddrBitWidth-1:0] ram_addr_out,
   input  logic [DataDepth-1:0]    ram_q
);
   localparam int DEPTH = 2**AddrBitWidth;
   localparam logic [AddrBitWidth:0]   CNT_DEPTH = DEPTH;
   localparam logic [AddrBitWidth:0]   CNT_ONE   = 1;
   localparam logic [AddrBitWidth-1:0] PTR_ONE   = 1;
   logic [AddrBitWidth-1:0] wr_ptr, rd_ptr;
   logic [1:0] rdy, gnt;
   logic push, pop;
   rr_arb2 u_arb (
      .clk1 (clk1),
      .rst_n(rst_n),
      .req  ({w1_valid, w0_valid}),
      .en   (!full & rst_n),
      .rdy  (rdy),
      .gnt  (gnt)
   );
   // full/empty come from count so wrapped pointers never alias
   always_comb begin
      full         = count == CNT_DEPTH;
      empty        = count == '0;
      w0_ready     = rdy[0];
      w1_ready     = rdy[1];
      push         = |gnt;
      pop          = !empty & r_ready;
      r_valid      = !empty;
      r_data       = ram_q;
      ram_we       = push;
      ram_addr_in  = wr_ptr;
      ram_d        = gnt[1] ? w1_data : w0_data;
      ram_addr_out = rd_ptr;
   end
   always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         count <= (push & !pop) ? count + CNT_ONE : (pop & !push) ? count - CNT_ONE : count;
      end
endmodule

// File: tb/tb_ram_fifo_arb.sv
// tb_ram_fifo_arb: randomized checks of ram_fifo_arb against a queue-based FIFO model
module tb_ram_fifo_arb;
   logic clk1 = 0, rst_n = 0;
   logic w0_valid = 0, w1_valid = 0, r_ready = 0;
   logic [7:0] w0_data = 0, w1_data = 0;
   logic w0_ready, w1_ready, r_valid, full, empty, ram_we;
   logic [7:0] r_data, ram_d, ram_q;
   logic [2:0] count;
   logic [1:0] ram_addr_in, ram_addr_out;
   logic [7:0] mem [4];
   int checks = 0, errors = 0;
   logic [7:0] q[$];
   bit m_last = 1;
   int wr_n = 0, rd_n = 0;

   always #5 clk1 = ~clk1;
   always @(posedge clk1) if (ram_we) mem[ram_addr_in] <= ram_d;
   assign ram_q = mem[ram_addr_out];

   ram_fifo_arb #(.DataDepth(8), .AddrBitWidth(2)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .w0_valid(w0_valid), .w0_data(w0_data), .w0_ready(w0_ready),
      .w1_valid(w1_valid), .w1_data(w1_data), .w1_ready(w1_ready),
      .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
      .count(count), .full(full), .empty(empty),
      .ram_we(ram_we), .ram_addr_in(ram_addr_in), .ram_d(ram_d),
      .ram_addr_out(ram_addr_out), .ram_q(ram_q)
   );

   // producer k may go when the FIFO has room and either the other is idle or k lost last time
   function automatic bit exp_rdy0();
      return q.size() < 4 && (!w1_valid || m_last == 1);
   endfunction
   function automatic bit exp_rdy1();
      return q.size() < 4 && (!w0_valid || m_last == 0);
   endfunction

   task automatic tick();
      bit a0, a1, p;
      a0 = w0_valid && exp_rdy0();
      a1 = w1_valid && exp_rdy1();
      p  = r_ready && q.size() > 0;
      @(posedge clk1);
      if (p) begin void'(q.pop_front()); rd_n++; end
      if (a0) begin q.push_back(w0_data); m_last = 0; wr_n++; end
      else if (a1) begin q.push_back(w1_data); m_last = 1; wr_n++; end
      #1;
   endtask

   task automatic model_reset();
      q.delete(); m_last = 1; wr_n = 0; rd_n = 0;
   endtask

   task automatic do_reset();
      w0_valid = 0; w1_valid = 0; r_ready = 0;
      rst_n = 0;
      @(negedge clk1);
      rst_n = 1;
      model_reset();
      @(posedge clk1); #1;
   endtask

   task automatic test_reset();
      w0_valid = 1; w1_valid = 1;
      #3;
      checks++; if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
      checks++; if (empty !== 1) begin errors++; $display("FAIL reset_empty: got %0b exp 1", empty); end
      checks++; if (full !== 0) begin errors++; $display("FAIL reset_full: got %0b exp 0", full); end
      checks++; if (r_valid !== 0) begin errors++; $display("FAIL reset_rvalid: got %0b exp 0", r_valid); end
      checks++; if ({w0_ready, w1_ready, ram_we} !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", {w0_ready, w1_ready, ram_we}); end
      do_reset();
   endtask

   task automatic test_single();
      w0_valid = 1; w0_data = 8'hA1;
      #1;
      checks++; if ({ram_we, w0_ready} !== 2'b11) begin errors++; $display("FAIL single_we: got %b exp 11", {ram_we, w0_ready}); end
      checks++; if (ram_addr_in !== 0) begin errors++; $display("FAIL single_addr: got %0d exp 0", ram_addr_in); end
      checks++; if (ram_d !== 8'hA1) begin errors++; $display("FAIL single_d: got %h exp a1", ram_d); end
      tick();
      w0_valid = 0;
      #1;
      checks++; if (r_valid !== 1) begin errors++; $display("FAIL single_rvalid: got %0b exp 1", r_valid); end
      checks++; if (r_data !== 8'hA1) begin errors++; $display("FAIL single_rdata: got %h exp a1", r_data); end
      checks++; if (count !== 1) begin errors++; $display("FAIL single_count: got %0d exp 1", count); end
      r_ready = 1;
      tick();
      r_ready = 0;
      #1;
      checks++; if (empty !== 1) begin errors++; $display("FAIL single_drain: got %0b exp 1", empty); end
   endtask

   task automatic test_contention();
      do_reset();
      w0_valid = 1; w1_valid = 1; w0_data = 8'h10; w1_data = 8'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({w0_ready, w1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contend_gnt%0d: got %b exp %b", i, {w0_ready, w1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         checks++; if (ram_d !== ((i % 2 == 0) ? w0_data : w1_data)) begin errors++; $display("FAIL contend_d%0d: got %h", i, ram_d); end
         tick();
         if (i % 2 == 0) w0_data++; else w1_data++;
      end
      #1;
      checks++; if ({full, count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL contend_full: got full=%0b count=%0d exp 1/4", full, count); end
      checks++; if ({w0_ready, w1_ready} !== 2'b00) begin errors++; $display("FAIL contend_rdy_full: got %b exp 00", {w0_ready, w1_ready}); end
   endtask

   task automatic test_full_pop();
      r_ready = 1;
      #1;
      checks++; if ({w0_ready, w1_ready} !== 2'b00) begin errors++; $display("FAIL fullpop_rdy: got %b exp 00", {w0_ready, w1_ready}); end
      checks++; if (r_data !== q[0]) begin errors++; $display("FAIL fullpop_head: got %h exp %h", r_data, q[0]); end
      tick();
      r_ready = 0;
      #1;
      checks++; if (count !== 3) begin errors++; $display("FAIL fullpop_count: got %0d exp 3", count); end
      checks++; if ({w0_ready, w1_ready} !== {exp_rdy0(), exp_rdy1()}) begin errors++; $display("FAIL fullpop_rdy_after: got %b exp %b", {w0_ready, w1_ready}, {exp_rdy0(), exp_rdy1()}); end
      w0_valid = 0; w1_valid = 0; r_ready = 1;
      for (int i = 0; i < 8 && q.size() > 0; i++) begin
         #1;
         checks++; if (r_data !== q[0]) begin errors++; $display("FAIL fullpop_drain%0d: got %h exp %h", i, r_data, q[0]); end
         tick();
      end
      r_ready = 0;
   endtask

   task automatic test_stream();
      int start = wr_n;
      r_ready = 1;
      for (int c = 0; c < 200 && wr_n - start < 10; c++) begin
         w0_valid = 1'($urandom); w1_valid = 1'($urandom);
         w0_data = 8'($urandom); w1_data = 8'($urandom);
         #1;
         checks++; if (count > 1 || count !== q.size()) begin errors++; $display("FAIL stream_count: got %0d exp %0d", count, q.size()); end
         checks++; if ({ram_addr_in, ram_addr_out} !== {2'(wr_n % 4), 2'(rd_n % 4)}) begin errors++; $display("FAIL stream_ptrs: got %0d/%0d exp %0d/%0d", ram_addr_in, ram_addr_out, wr_n % 4, rd_n % 4); end
         if (q.size() > 0) begin
            checks++; if (r_data !== q[0]) begin errors++; $display("FAIL stream_data: got %h exp %h", r_data, q[0]); end
         end
         tick();
      end
      checks++; if (wr_n - start < 10) begin errors++; $display("FAIL stream_timeout: got %0d words exp 10", wr_n - start); end
      w0_valid = 0; w1_valid = 0;
      tick(); tick();
      r_ready = 0;
   endtask

   task automatic test_push_pop();
      do_reset();
      w0_valid = 1; w0_data = 8'h31; tick();
      w0_data = 8'h32; tick();
      w0_valid = 0;
      #1;
      checks++; if (count !== 2) begin errors++; $display("FAIL pp_count_before: got %0d exp 2", count); end
      w1_valid = 1; w1_data = 8'h33; r_ready = 1;
      #1;
      checks++; if ({w1_ready, r_data} !== {1'b1, 8'h31}) begin errors++; $display("FAIL pp_same_cycle: got rdy=%0b data=%h exp 1/31", w1_ready, r_data); end
      tick();
      w1_valid = 0; r_ready = 0;
      #1;
      checks++; if (count !== 2) begin errors++; $display("FAIL pp_count: got %0d exp 2", count); end
      checks++; if ({ram_addr_in, ram_addr_out} !== {2'd3, 2'd1}) begin errors++; $display("FAIL pp_ptrs: got %0d/%0d exp 3/1", ram_addr_in, ram_addr_out); end
      checks++; if (r_data !== 8'h32) begin errors++; $display("FAIL pp_head: got %h exp 32", r_data); end
   endtask

   task automatic test_async_reset();
      do_reset();
      w0_valid = 1;
      for (int i = 0; i < 3; i++) begin w0_data = 8'h41 + 8'(i); tick(); end
      w0_valid = 0;
      #1;
      checks++; if (count !== 3) begin errors++; $display("FAIL arst_fill: got %0d exp 3", count); end
      w0_valid = 1; w1_valid = 1;
      #1;
      rst_n = 0;
      #1;
      checks++; if ({r_valid, w0_ready, w1_ready, ram_we} !== 4'b0000) begin errors++; $display("FAIL arst_outputs: got %b exp 0000", {r_valid, w0_ready, w1_ready, ram_we}); end
      checks++; if ({count, empty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL arst_count: got %0d/%0b exp 0/1", count, empty); end
      w0_valid = 0; w1_valid = 0;
      @(negedge clk1);
      rst_n = 1;
      model_reset();
      @(posedge clk1); #1;
      w0_valid = 1; w0_data = 8'h5C;
      #1;
      checks++; if ({w0_ready, ram_addr_in} !== {1'b1, 2'd0}) begin errors++; $display("FAIL arst_first: got rdy=%0b addr=%0d exp 1/0", w0_ready, ram_addr_in); end
      tick();
      w0_valid = 0;
      #1;
      checks++; if ({r_valid, r_data} !== {1'b1, 8'h5C}) begin errors++; $display("FAIL arst_readback: got %0b/%h exp 1/5c", r_valid, r_data); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         w0_valid = ($urandom % 4) != 0; w1_valid = ($urandom % 3) == 0;
         w0_data = 8'($urandom); w1_data = 8'($urandom);
         r_ready = ($urandom % 2) == 0;
         #1;
         checks++; if ({w0_ready, w1_ready} !== {exp_rdy0(), exp_rdy1()}) begin errors++; $display("FAIL rand_rdy: got %b exp %b", {w0_ready, w1_ready}, {exp_rdy0(), exp_rdy1()}); end
         checks++; if ({count, full, empty, r_valid} !== {3'(q.size()), q.size() == 4, q.size() == 0, q.size() > 0}) begin errors++; $display("FAIL rand_status: got cnt=%0d f=%0b e=%0b v=%0b exp cnt=%0d", count, full, empty, r_valid, q.size()); end
         if (q.size() > 0) begin
            checks++; if (r_data !== q[0]) begin errors++; $display("FAIL rand_data: got %h exp %h", r_data, q[0]); end
         end
         tick();
      end
      w0_valid = 0; w1_valid = 0; r_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_full_pop();
      test_stream();
      test_push_pop();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
